// File: rtl/counter_pkg.sv
// Shared constants and helpers for the counter timebase.
// Optional load port support is enabled with the COUNTER_LOAD_EN macro.
package counter_pkg;

  localparam int COUNTER_WIDTH_DEF    = 4;
  localparam int COUNTER_MODULUS_DEF  = 16;
  localparam int COUNTER_PRESCALE_DEF = 1;

  // Prescaler register width: enough bits to hold 0..prescale-1, never zero.
  function automatic int prescale_width(input int prescale);
    int w;
    w = $clog2(prescale);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Divides the clock into a one-cycle tick every PRESCALE rising edges.
// With PRESCALE=1 the tick is a constant 1 and no state is kept.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = COUNTER_PRESCALE_DEF
) (
  input  logic clock,
  input  logic res,
  input  logic clear,
  output logic tick
);

  generate
    if (PRESCALE == 1) begin : g_bypass
      logic unused_inputs;
      assign unused_inputs = clock ^ res ^ clear;
      assign tick          = 1'b1;
    end else begin : g_div
      localparam int            PW   = prescale_width(PRESCALE);
      localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

      logic [PW-1:0] cnt_q;
      logic [PW-1:0] cnt_d;

      // clear restarts the phase so the next tick is a full PRESCALE edges away.
      always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
          cnt_d = '0;
        end else if (cnt_q >= LAST) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + PW'(1);
        end
      end

      always_ff @(posedge clock or negedge res) begin
        if (!res) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign tick = (cnt_q == LAST);
    end
  endgenerate

endmodule

// File: rtl/counter.sv
// Free-running modulo up-counter with optional prescaler.
// Define COUNTER_LOAD_EN to add the synchronous load/load_value ports.
module counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = COUNTER_WIDTH_DEF,
  parameter int MODULUS  = COUNTER_MODULUS_DEF,
  parameter int PRESCALE = COUNTER_PRESCALE_DEF
) (
  input  logic             clock,
  input  logic             res,
`ifdef COUNTER_LOAD_EN
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
`endif
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic             tick;
  logic             clear;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clock (clock),
    .res   (res),
    .clear (clear),
    .tick  (tick)
  );

`ifdef COUNTER_LOAD_EN
  localparam logic [WIDTH:0] MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic load_in_range;
  assign load_in_range = ({1'b0, load_value} < MOD_EXT);
  assign clear         = load;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_in_range ? load_value : '0;
    end else if (tick) begin
      // >= rather than == so an out-of-range value recovers on the next tick.
      count_d = (count_q >= LAST) ? '0 : count_q + WIDTH'(1);
    end
  end

  assign wrap = tick & (count_q == LAST) & ~load;
`else
  assign clear = 1'b0;

  always_comb begin
    count_d = count_q;
    if (tick) begin
      // >= rather than == so an out-of-range value recovers on the next tick.
      count_d = (count_q >= LAST) ? '0 : count_q + WIDTH'(1);
    end
  end

  assign wrap = tick & (count_q == LAST);
`endif

  always_ff @(posedge clock or negedge res) begin
    if (!res) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_counter.sv
// Directed bench for counter: default build, a MODULUS=10/PRESCALE=3 instance,
// and a WIDTH=5 instance exercising load when COUNTER_LOAD_EN is defined.
module tb_counter;

  typedef struct {
    logic       res;
    logic [3:0] exp_count;
    logic       exp_wrap;
  } vec_t;

  logic       clk;
  logic       res_d;
  logic       res_p;
  logic [3:0] cnt_d;
  logic       wrap_d;
  logic [3:0] cnt_p;
  logic       wrap_p;
`ifdef COUNTER_LOAD_EN
  logic       res_l;
  logic       load_l;
  logic [4:0] load_value_l;
  logic [4:0] cnt_l;
  logic       wrap_l;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [4:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: time %0t reached limit 100000", $time);
    $fatal(1, "timeout");
  end

  // ---------------- DUTs ----------------
  counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(1)) dut_def (
    .clock      (clk),
    .res        (res_d),
`ifdef COUNTER_LOAD_EN
    .load       (1'b0),
    .load_value (4'd0),
`endif
    .count      (cnt_d),
    .wrap       (wrap_d)
  );

  counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) dut_p (
    .clock      (clk),
    .res        (res_p),
`ifdef COUNTER_LOAD_EN
    .load       (1'b0),
    .load_value (4'd0),
`endif
    .count      (cnt_p),
    .wrap       (wrap_p)
  );

`ifdef COUNTER_LOAD_EN
  counter #(.WIDTH(5), .MODULUS(16), .PRESCALE(1)) dut_l (
    .clock      (clk),
    .res        (res_l),
    .load       (load_l),
    .load_value (load_value_l),
    .count      (cnt_l),
    .wrap       (wrap_l)
  );
`endif

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // ---------------- stimulus and scoreboard ----------------
  vec_t def_vec[20];

  initial begin
    int   n_wrap;
    logic [4:0] exp;

    def_vec = '{
      '{1'b1, 4'd1,  1'b0}, '{1'b1, 4'd2,  1'b0}, '{1'b1, 4'd3,  1'b0},
      '{1'b1, 4'd4,  1'b0}, '{1'b1, 4'd5,  1'b0}, '{1'b1, 4'd6,  1'b0},
      '{1'b1, 4'd7,  1'b0}, '{1'b1, 4'd8,  1'b0}, '{1'b1, 4'd9,  1'b0},
      '{1'b1, 4'd10, 1'b0}, '{1'b1, 4'd11, 1'b0}, '{1'b1, 4'd12, 1'b0},
      '{1'b1, 4'd13, 1'b0}, '{1'b1, 4'd14, 1'b0}, '{1'b1, 4'd15, 1'b1},
      '{1'b1, 4'd0,  1'b0}, '{1'b1, 4'd1,  1'b0}, '{1'b1, 4'd2,  1'b0},
      '{1'b1, 4'd3,  1'b0}, '{1'b1, 4'd4,  1'b0}
    };

    res_d = 1'b0;
    res_p = 1'b0;
`ifdef COUNTER_LOAD_EN
    res_l        = 1'b0;
    load_l       = 1'b0;
    load_value_l = 5'd0;
`endif

    // Reset held across three edges.
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_hold_count", 32'(cnt_d), 32'd0);
      check("rst_hold_wrap",  32'(wrap_d), 32'd0);
      check("rst_hold_count_p", 32'(cnt_p), 32'd0);
      check("rst_hold_wrap_p",  32'(wrap_p), 32'd0);
    end

    // Release and run the default sequence from the vector table.
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      res_d = def_vec[i].res;
      step();
      check($sformatf("seq_count[%0d]", i), 32'(cnt_d),  32'(def_vec[i].exp_count));
      check($sformatf("seq_wrap[%0d]", i),  32'(wrap_d), 32'(def_vec[i].exp_wrap));
    end

    // Advance to 9, then assert reset asynchronously between edges.
    repeat (5) step();
    check("pre_reset_count", 32'(cnt_d), 32'd9);
    #2;
    res_d = 1'b0;
    #1;
    check("async_reset_count", 32'(cnt_d), 32'd0);
    check("async_reset_wrap",  32'(wrap_d), 32'd0);
    #19;
    res_d = 1'b1;
    step();
    check("post_release_count1", 32'(cnt_d), 32'd1);
    step();
    check("post_release_count2", 32'(cnt_d), 32'd2);

    // MODULUS=10 PRESCALE=3: count k/3 mod 10, wrap only in the cycle before 9->0.
    for (int k = 1; k <= 35; k++) begin
      exp[3:0] = 4'((k / 3) % 10);
      exp[4]   = ((k % 3) == 2) && (exp[3:0] == 4'd9);
      exp_q.push_back(exp);
    end
    n_wrap = 0;
    @(negedge clk);
    res_p = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      step();
      exp = exp_q.pop_front();
      check($sformatf("pre_count[%0d]", k), 32'(cnt_p),  32'(exp[3:0]));
      check($sformatf("pre_wrap[%0d]", k),  32'(wrap_p), 32'(exp[4]));
      if (wrap_p === 1'b1) n_wrap++;
    end
    check("pre_wrap_total", 32'(n_wrap), 32'd1);

`ifdef COUNTER_LOAD_EN
    @(negedge clk);
    res_l = 1'b1;
    repeat (3) step();
    check("load_pre_count", 32'(cnt_l), 32'd3);
    @(negedge clk);
    load_l       = 1'b1;
    load_value_l = 5'd12;
    step();
    check("load_12", 32'(cnt_l), 32'd12);
    @(negedge clk);
    load_l = 1'b0;
    step();
    check("load_then_13", 32'(cnt_l), 32'd13);
    @(negedge clk);
    load_l       = 1'b1;
    load_value_l = 5'd20;
    step();
    check("load_out_of_range", 32'(cnt_l), 32'd0);
    @(negedge clk);
    load_l = 1'b0;
    repeat (15) step();
    check("load_run_to_15", 32'(cnt_l), 32'd15);
    check("load_wrap_before", 32'(wrap_l), 32'd1);
    @(negedge clk);
    load_l       = 1'b1;
    load_value_l = 5'd5;
    #1;
    check("load_wrap_forced_low", 32'(wrap_l), 32'd0);
    step();
    check("load_5", 32'(cnt_l), 32'd5);
    @(negedge clk);
    load_l = 1'b0;
`endif

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
